// File: rtl/cp_remove_pkg.sv
// Shared constants, FSM state encoding and segment-length helper for cp_remove.
package cp_remove_pkg;

  localparam int unsigned DW      = 12;   // sample width per I/Q rail
  localparam int unsigned N_FFT   = 512;  // samples per symbol body
  localparam int unsigned LOG_FFT = 9;    // log2(N_FFT)
  localparam int unsigned N_CP    = 32;   // data-symbol cyclic prefix length
  localparam int unsigned N_PRE   = 8;    // preamble symbols (no CP)
  localparam int unsigned N_DATA  = 6;    // data symbols per packet
  localparam int unsigned CW      = 13;   // sample counter width (holds N_PRE*N_FFT-1)
  localparam int unsigned SW      = 4;    // symbol counter width

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_CP   = 3'd2,
    ST_BODY = 3'd3,
    ST_TAIL = 3'd4
  } state_t;

  // Terminal count (last sample index) of the segment framed by a given state.
  function automatic logic [CW-1:0] seg_last(input state_t st, input int unsigned backoff);
    case (st)
      ST_PRE:  seg_last = CW'(N_PRE * N_FFT - 1);
      ST_CP:   seg_last = CW'(N_CP - backoff - 1);
      ST_BODY: seg_last = CW'(N_FFT - 1);
      ST_TAIL: seg_last = (backoff == 0) ? '0 : CW'(backoff - 1);
      default: seg_last = '0;
    endcase
  endfunction

endpackage

// File: rtl/cp_remove_seg_counter.sv
// Sample-qualified terminal-count counter.
//  clk, rst    clock, async active-low reset
//  vld         sample qualifier; ld and inc only act on qualified samples
//  inc         advance request (wraps to 0 after reaching last)
//  clr         unconditional synchronous clear (highest priority)
//  ld, ld_val  load a value on a qualified sample
//  last        terminal count for the current segment
//  cnt, tc_c   count and combinational terminal-count flag
module seg_counter #(
  parameter int unsigned W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld,
  input  logic         inc,
  input  logic         clr,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic [W-1:0] last,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  assign tc_c = (cnt == last);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (vld && ld) begin
      cnt <= ld_val;
    end else if (vld && inc) begin
      cnt <= tc_c ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/cp_remove.sv
// Cyclic-prefix removal and symbol framing for the CFO-corrected sample stream.
//  clk, rst             clock, async active-low reset
//  di_re/di_im/di_vld   input samples and qualifier
//  pkt_start            first preamble sample marker (qualified by di_vld)
//  do_re/do_im/do_vld   framed output samples (1-cycle latency)
//  do_sos, do_sym_idx   start-of-symbol and symbol index tags
//  do_is_pre            sample belongs to the preamble
//  pkt_done, pkt_abort  end-of-packet and restart pulses
module cp_remove
  import cp_remove_pkg::*;
#(
  parameter int unsigned CP_BACKOFF = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] di_re,
  input  logic [DW-1:0] di_im,
  input  logic          di_vld,
  input  logic          pkt_start,
  output logic [DW-1:0] do_re,
  output logic [DW-1:0] do_im,
  output logic          do_vld,
  output logic          do_sos,
  output logic [SW-1:0] do_sym_idx,
  output logic          do_is_pre,
  output logic          pkt_done,
  output logic          pkt_abort
);

  localparam logic HAS_TAIL = (CP_BACKOFF != 0);

  state_t        state;
  logic          start;
  logic [CW-1:0] samp_cnt;
  logic          samp_tc;
  logic [SW-1:0] sym_cnt;
  logic          sym_tc;
  logic          idle_clr;
  logic          pre_sym_end;
  logic          body_end;
  logic          emit;

  assign start       = pkt_start && di_vld;
  assign idle_clr    = (state == ST_IDLE) && !start;
  // Preamble symbols are not separately framed; each 512-sample boundary bumps the index.
  assign pre_sym_end = (state == ST_PRE) && (samp_cnt[LOG_FFT-1:0] == LOG_FFT'(N_FFT - 1));
  assign body_end    = (state == ST_BODY) && samp_tc;
  assign emit        = start || (di_vld && ((state == ST_PRE) || (state == ST_BODY)));

  // Position within the current segment; the start sample itself is index 0, so load 1.
  seg_counter #(.W(CW)) u_samp_cnt (
    .clk    (clk),
    .rst    (rst),
    .vld    (di_vld),
    .inc    (state != ST_IDLE),
    .clr    (idle_clr),
    .ld     (pkt_start),
    .ld_val (CW'(1)),
    .last   (seg_last(state, CP_BACKOFF)),
    .cnt    (samp_cnt),
    .tc_c   (samp_tc)
  );

  // Symbol index; wraps to 0 after the last data body, which marks the final TAIL.
  seg_counter #(.W(SW)) u_sym_cnt (
    .clk    (clk),
    .rst    (rst),
    .vld    (di_vld),
    .inc    (pre_sym_end || body_end),
    .clr    (idle_clr),
    .ld     (pkt_start),
    .ld_val ('0),
    .last   (SW'(N_PRE + N_DATA - 1)),
    .cnt    (sym_cnt),
    .tc_c   (sym_tc)
  );

  // Framing FSM and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      do_re      <= '0;
      do_im      <= '0;
      do_vld     <= 1'b0;
      do_sos     <= 1'b0;
      do_sym_idx <= '0;
      do_is_pre  <= 1'b0;
      pkt_done   <= 1'b0;
      pkt_abort  <= 1'b0;
    end else begin
      do_vld    <= emit;
      do_sos    <= start || (di_vld && (((state == ST_PRE) && (samp_cnt[LOG_FFT-1:0] == '0)) ||
                                        ((state == ST_BODY) && (samp_cnt == '0))));
      pkt_done  <= di_vld && !pkt_start && body_end && sym_tc;
      pkt_abort <= start && (state != ST_IDLE);

      if (emit) begin
        do_re      <= di_re;
        do_im      <= di_im;
        do_sym_idx <= start ? '0 : sym_cnt;
        do_is_pre  <= start || (state == ST_PRE);
      end

      if (start) begin
        state <= ST_PRE;
      end else if (di_vld) begin
        case (state)
          ST_PRE:  if (samp_tc) state <= ST_CP;
          ST_CP:   if (samp_tc) state <= ST_BODY;
          ST_BODY: if (samp_tc) begin
            if (HAS_TAIL)    state <= ST_TAIL;
            else if (sym_tc) state <= ST_IDLE;
            else             state <= ST_CP;
          end
          ST_TAIL: if (samp_tc) state <= (sym_cnt == '0) ? ST_IDLE : ST_CP;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cp_remove.sv
// Self-checking bench: two instances (CP_BACKOFF 4 and 0) share one randomized stream
// and are compared every cycle against a packet-position reference model.
module tb_cp_remove;
  import cp_remove_pkg::*;

  localparam int PKT_LEN = 4096 + 6 * 544;  // input samples per packet

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] di_re = '0;
  logic [DW-1:0] di_im = '0;
  logic          di_vld = 1'b0;
  logic          pkt_start = 1'b0;

  logic [DW-1:0] o_re   [2];
  logic [DW-1:0] o_im   [2];
  logic          o_vld  [2];
  logic          o_sos  [2];
  logic [SW-1:0] o_idx  [2];
  logic          o_pre  [2];
  logic          o_done [2];
  logic          o_abort[2];

  always #5 clk = ~clk;

  cp_remove #(.CP_BACKOFF(4)) dut4 (
    .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .pkt_start(pkt_start), .do_re(o_re[0]), .do_im(o_im[0]), .do_vld(o_vld[0]),
    .do_sos(o_sos[0]), .do_sym_idx(o_idx[0]), .do_is_pre(o_pre[0]),
    .pkt_done(o_done[0]), .pkt_abort(o_abort[0])
  );

  cp_remove #(.CP_BACKOFF(0)) dut0 (
    .clk(clk), .rst(rst), .di_re(di_re), .di_im(di_im), .di_vld(di_vld),
    .pkt_start(pkt_start), .do_re(o_re[1]), .do_im(o_im[1]), .do_vld(o_vld[1]),
    .do_sos(o_sos[1]), .do_sym_idx(o_idx[1]), .do_is_pre(o_pre[1]),
    .pkt_done(o_done[1]), .pkt_abort(o_abort[1])
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: p is the sample's position inside the packet, -1 when idle.
  int            p = -1;
  logic [DW-1:0] m_re [2];
  logic [DW-1:0] m_im [2];
  int            e_idx[2];
  logic          e_vld[2], e_sos[2], e_pre[2], e_done[2], e_abort;
  int            n_done[2];

  task automatic chk(input string tag, input int b, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s bk%0d: got %0h expected %0h at %0t", tag, (b == 0) ? 4 : 0, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    p = -1;
    e_abort = 1'b0;
    for (int b = 0; b < 2; b++) begin
      m_re[b] = '0; m_im[b] = '0; e_idx[b] = 0;
      e_vld[b] = 1'b0; e_sos[b] = 1'b0; e_pre[b] = 1'b0; e_done[b] = 1'b0;
    end
  endtask

  task automatic model_step(input logic v, input logic s, input logic [DW-1:0] r, input logic [DW-1:0] i);
    int bk, q, k, rr, first, lastr;
    e_abort = 1'b0;
    for (int b = 0; b < 2; b++) begin
      e_vld[b] = 1'b0; e_sos[b] = 1'b0; e_done[b] = 1'b0;
    end
    if (v) begin
      if (s) begin
        e_abort = (p >= 0);
        p = 0;
      end else if (p >= 0) begin
        p++;
      end
      if (p >= 0) begin
        for (int b = 0; b < 2; b++) begin
          bk = (b == 0) ? 4 : 0;
          if (p < 4096) begin
            e_vld[b] = 1'b1; e_idx[b] = p / 512; e_pre[b] = 1'b1; e_sos[b] = (p % 512 == 0);
          end else begin
            q = p - 4096; k = q / 544; rr = q % 544;
            first = 32 - bk; lastr = 543 - bk;
            if (rr >= first && rr <= lastr) begin
              e_vld[b] = 1'b1; e_idx[b] = 8 + k; e_pre[b] = 1'b0;
              e_sos[b] = (rr == first);
              e_done[b] = (k == 5) && (rr == lastr);
            end
          end
          if (e_vld[b]) begin
            m_re[b] = r; m_im[b] = i;
          end
          if (e_done[b]) n_done[b]++;
        end
        if (p == PKT_LEN - 1) p = -1;
      end
    end
  endtask

  task automatic check_outputs();
    for (int b = 0; b < 2; b++) begin
      chk("vld",   b, 32'(o_vld[b]),   32'(e_vld[b]));
      chk("re",    b, 32'(o_re[b]),    32'(m_re[b]));
      chk("im",    b, 32'(o_im[b]),    32'(m_im[b]));
      chk("sos",   b, 32'(o_sos[b]),   32'(e_sos[b]));
      chk("done",  b, 32'(o_done[b]),  32'(e_done[b]));
      chk("abort", b, 32'(o_abort[b]), 32'(e_abort));
      if (e_vld[b]) begin
        chk("sym_idx", b, 32'(o_idx[b]), 32'(e_idx[b]));
        chk("is_pre",  b, 32'(o_pre[b]), 32'(e_pre[b]));
      end
    end
  endtask

  task automatic check_zero(input string tag);
    for (int b = 0; b < 2; b++) begin
      chk({tag, "_vld"},   b, 32'(o_vld[b]),   32'd0);
      chk({tag, "_re"},    b, 32'(o_re[b]),    32'd0);
      chk({tag, "_im"},    b, 32'(o_im[b]),    32'd0);
      chk({tag, "_sos"},   b, 32'(o_sos[b]),   32'd0);
      chk({tag, "_idx"},   b, 32'(o_idx[b]),   32'd0);
      chk({tag, "_pre"},   b, 32'(o_pre[b]),   32'd0);
      chk({tag, "_done"},  b, 32'(o_done[b]),  32'd0);
      chk({tag, "_abort"}, b, 32'(o_abort[b]), 32'd0);
    end
  endtask

  // One clock of stimulus; outputs are checked 1 time unit after the edge.
  task automatic drive(input logic v, input logic s, input logic [DW-1:0] r, input logic [DW-1:0] i);
    di_vld = v; pkt_start = s; di_re = r; di_im = i;
    model_step(v, s, r, i);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'($urandom), DW'($urandom), DW'($urandom));
  endtask

  // Ramp on re, random im; gappy mode alternates idle cycles and adds random 20-cycle gaps.
  task automatic send_stream(input int count, input int restart_at, input bit gappy);
    for (int n = 0; n < count; n++) begin
      if (gappy) begin
        idle_cycle();
        if ($urandom_range(0, 199) == 0)
          for (int g = 0; g < 20; g++) idle_cycle();
      end
      drive(1'b1, (n == 0) || (n == restart_at), DW'(n), DW'($urandom));
    end
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0; di_vld = 1'b0; pkt_start = 1'b0;
    #1;
    model_reset();
    check_zero("rst_async");
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int done_ref[2];
    model_reset();
    n_done[0] = 0; n_done[1] = 0;
    #2 rst = 1'b0;
    #1 check_zero("reset");
    repeat (3) @(posedge clk);
    #1 check_zero("reset_hold");
    @(negedge clk);
    rst = 1'b1;

    // pkt_start without di_vld is ignored; stray samples in IDLE are dropped
    drive(1'b0, 1'b1, DW'($urandom), DW'($urandom));
    for (int n = 0; n < 100; n++) drive(1'b1, 1'b0, DW'($urandom), DW'($urandom));

    // continuous packet, then a few idle cycles
    send_stream(PKT_LEN, -1, 1'b0);
    for (int n = 0; n < 10; n++) drive(1'b1, 1'b0, DW'($urandom), DW'($urandom));

    // same packet with 1010 valid pattern and random gaps
    send_stream(PKT_LEN, -1, 1'b1);

    // restart at preamble sample 1000, then the full packet
    send_stream(1000 + PKT_LEN, 1000, 1'b0);

    // asynchronous reset mid-packet, then a clean packet
    send_stream(3000, -1, 1'b0);
    async_reset();
    send_stream(PKT_LEN, -1, 1'b0);
    for (int n = 0; n < 5; n++) idle_cycle();

    // four full packets completed; the aborted and reset ones must not count
    done_ref[0] = 4; done_ref[1] = 4;
    for (int b = 0; b < 2; b++) chk("model_done_count", b, 32'(n_done[b]), 32'(done_ref[b]));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
